fpmult_arbiter: RTL and testbench

FPMULT_ARBITER -- requirements
Module: fpmult_arbiter

---
 rtl/fpmult_pkg.sv | 19 +
 rtl/fpmult_rr_arb.sv | 42 ++++
 rtl/fpmult_arbiter.sv | 124 ++++++++++++
 tb/tb_fpmult_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fpmult_pkg.sv
// Shared definitions for the FP32 multiplier arbiter: field widths, default latency, pipeline tag.
package fpmult_pkg;

    localparam int FP_SGN_W = 1;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_W     = FP_SGN_W + FP_EXP_W + FP_MAN_W;

    localparam int DEF_LAT  = 4;

    // Wide enough for any practical requester count.
    localparam int TAG_ID_W = 8;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } fpmult_tag_t;

endpackage

// File: rtl/fpmult_rr_arb.sv
// Request arbiter: round-robin from ptr_i+1, or fixed lowest-index priority when
// FPMULT_ARB_FIXED_PRIO_EN is defined. Produces a one-hot grant and the winner index.
module fpmult_rr_arb #(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        int cand;
        gnt_o = '0;
        idx_o = ptr_i;
        any_o = 1'b0;
        cand  = 0;
`ifdef FPMULT_ARB_FIXED_PRIO_EN
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                cand = k;
                any_o = 1'b1;
            end
        end
`else
        // Walk downward so the candidate closest after the pointer is kept last.
        for (int k = NREQ; k >= 1; k--) begin
            if (req_i[(int'(ptr_i) + k) % NREQ]) begin
                cand  = (int'(ptr_i) + k) % NREQ;
                any_o = 1'b1;
            end
        end
`endif
        if (any_o) begin
            gnt_o[cand] = 1'b1;
            idx_o       = IDX_W'(cand);
        end
    end

endmodule

// File: rtl/fpmult_arbiter.sv
// Shares one pipelined FP32 multiplier among NREQ requesters and routes products back
// in issue order. Define FPMULT_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module fpmult_arbiter
    import fpmult_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = DEF_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [32*NREQ-1:0] a_in,
    input  logic [32*NREQ-1:0] b_in,
    output logic [NREQ-1:0]    gnt,
    output logic               mul_start,
    output logic [31:0]        mul_a,
    output logic [31:0]        mul_b,
    input  logic [31:0]        mul_p,
    output logic [NREQ-1:0]    res_valid,
    output logic [31:0]        res_data,
    output logic               busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grant_idx;
    logic [NREQ-1:0]  arb_gnt;
    logic             arb_any, grant_fire;
    logic [FP_W-1:0]  a_sel, b_sel;

    logic             mul_start_q;
    logic [FP_W-1:0]  mul_a_q, mul_b_q;
    logic [IDX_W-1:0] iss_id_q;

    fpmult_tag_t      tag_q [LAT];
    logic             tag_any;

    logic [NREQ-1:0]  res_valid_q, res_valid_d;
    logic [FP_W-1:0]  res_data_q;

    fpmult_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (grant_idx),
        .any_o (arb_any)
    );

    assign grant_fire = arb_any & ~rst;
    assign gnt        = rst ? '0 : arb_gnt;
    assign ptr_d      = grant_fire ? grant_idx : ptr_q;
    assign a_sel      = a_in[FP_W*grant_idx +: FP_W];
    assign b_sel      = b_in[FP_W*grant_idx +: FP_W];

    // Issue stage: operands and owner id travel together with mul_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= IDX_W'(NREQ - 1);
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            iss_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            mul_start_q <= grant_fire;
            iss_id_q    <= grant_idx;
            if (grant_fire) begin
                mul_a_q <= a_sel;
                mul_b_q <= b_sel;
            end
        end
    end

    // Tag pipe mirrors the multiplier: the last stage is valid exactly when mul_p is.
    for (genvar gi = 0; gi < LAT; gi++) begin : g_tag
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tag_q[gi] <= '0;
            end else if (gi == 0) begin
                tag_q[gi] <= '{valid: mul_start_q, id: TAG_ID_W'(iss_id_q)};
            end else begin
                tag_q[gi] <= tag_q[(gi > 0) ? gi - 1 : 0];
            end
        end
    end

    always_comb begin
        tag_any = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            tag_any = tag_any | tag_q[k].valid;
        end
    end

    always_comb begin
        res_valid_d = '0;
        for (int k = 0; k < NREQ; k++) begin
            res_valid_d[k] = tag_q[LAT-1].valid && (tag_q[LAT-1].id == TAG_ID_W'(k));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= '0;
            res_data_q  <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            if (tag_q[LAT-1].valid) begin
                res_data_q <= mul_p;
            end
        end
    end

    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = mul_start_q | tag_any | (|res_valid_q);

endmodule

// File: tb/tb_fpmult_arbiter.sv
// Scoreboard bench for fpmult_arbiter with a behavioural LAT-stage multiplier stub.
module tb_fpmult_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [32*NREQ-1:0] a_in, b_in;
    logic [NREQ-1:0]    gnt;
    logic               mul_start;
    logic [31:0]        mul_a, mul_b, mul_p;
    logic [NREQ-1:0]    res_valid;
    logic [31:0]        res_data;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [NREQ-1:0] mask;
        logic [31:0]     data;
        int              due;
    } exp_t;
    exp_t sb_q[$];

    // Hand-computed products for each requester's fixed operand pair.
    logic [31:0] prod_tab [NREQ];

    fpmult_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .res_valid(res_valid), .res_data(res_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fp_mul_lookup(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h3F800000}: return 32'h3F800000; // 1.0 * 1.0
            {32'hC0000000, 32'h40400000}: return 32'hC0C00000; // -2.0 * 3.0
            {32'h40000000, 32'h3FC00000}: return 32'h40400000; // 2.0 * 1.5
            {32'h3F000000, 32'h40800000}: return 32'h40000000; // 0.5 * 4.0
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    logic [31:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= mul_start ? fp_mul_lookup(mul_a, mul_b) : 32'h0;
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_p = mpipe[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every result must match the oldest expected entry, on its due cycle.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (res_valid != '0) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 32'(res_valid), 32'h0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("res_valid", 32'(res_valid), 32'(e.mask));
                    check("res_data", res_data, e.data);
                    check("res_cycle", 32'(cyc), 32'(e.due));
                    $display("result mask=%b data=0x%08h cycle=%0d", res_valid, res_data, cyc);
                end
            end else if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
                exp_t e;
                e = sb_q.pop_front();
                check("missing_result", 32'(res_valid), 32'(e.mask));
            end
        end
    end

    // Called just after a rising edge; checks gnt mid-cycle and returns just after the next edge.
    task automatic issue(input logic [NREQ-1:0] r, input logic [NREQ-1:0] exp_g, input bit push);
        req = r;
        @(negedge clk);
        check("gnt", 32'(gnt), 32'(exp_g));
        $display("issue req=%b gnt=%b expected=%b cycle=%0d", r, gnt, exp_g, cyc);
        if (push && exp_g != '0) begin
            exp_t e;
            for (int i = 0; i < NREQ; i++) begin
                if (exp_g[i]) e.data = prod_tab[i];
            end
            e.mask = exp_g;
            e.due  = cyc + LAT + 2;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        req = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy && sb_q.size() == 0) begin
                check("idle", 32'(busy), 32'h0);
                @(posedge clk);
                #1;
                return;
            end
        end
        check("idle_timeout", 32'(sb_q.size()) + 32'(busy), 32'h0);
        sb_q.delete();
        @(posedge clk);
        #1;
    endtask

    logic [NREQ-1:0] rr_seq  [5];
    logic [NREQ-1:0] b2b_seq [3];

    initial begin
`ifdef FPMULT_ARB_FIXED_PRIO_EN
        rr_seq  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        b2b_seq = '{4'b0010, 4'b0010, 4'b0010};
`else
        rr_seq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        b2b_seq = '{4'b0010, 4'b1000, 4'b0010};
`endif
        a_in = {32'h3F000000, 32'h40000000, 32'hC0000000, 32'h3F800000};
        b_in = {32'h40800000, 32'h3FC00000, 32'h40400000, 32'h3F800000};
        prod_tab = '{32'h3F800000, 32'hC0C00000, 32'h40400000, 32'h40000000};

        rst = 1'b1;
        req = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("gnt_in_reset", 32'(gnt), 32'h0);
        check("rst_mul_start", 32'(mul_start), 32'h0);
        check("rst_res_valid", 32'(res_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_mul_a", mul_a, 32'h0);
        check("rst_res_data", res_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All four requesting: rotating grants, each result in issue order.
        for (int i = 0; i < 5; i++) issue(4'b1111, rr_seq[i], 1'b1);
        wait_idle();

        // Back-to-back grants among requesters 1 and 3.
        for (int i = 0; i < 3; i++) issue(4'b1010, b2b_seq[i], 1'b1);
        wait_idle();

        // Single requester 2: 2.0 * 1.5.
        issue(4'b0100, 4'b0100, 1'b1);
        wait_idle();
        check("hold_res_data", res_data, 32'h40400000);

        // Reset two cycles after a grant must drop the operation.
        issue(4'b0001, 4'b0001, 1'b0);
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        req = 4'b1000;
        #1;
        check("gnt_in_reset_mid", 32'(gnt), 32'h0);
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        check("busy_after_rst", 32'(busy), 32'h0);
        issue(4'b1000, 4'b1000, 1'b1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
